// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the ping-pong frame buffer.
package frame_buffer_pkg;

  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  typedef logic bank_t;

  // One code point above DEPTH-1 so out-of-range addresses are always expressible.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// Single-clock simple dual-port RAM: one write port, one registered read port, no reset.
module bram_sdp #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: writer fills the back bank, reader scans the front bank,
// banks swap only at a reader frame boundary.
module frame_buffer_pingpong
  import frame_buffer_pkg::*;
#(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RD_LAT  = 1,
  localparam int unsigned DEPTH  = IMG_W * IMG_H,
  localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_frame_end,
  output logic              front_bank,
  output logic              swap_pending,
  output logic [15:0]       swap_count,
  output logic              wr_err
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_e      state_q;
  bank_t       front_q;
  logic        ready_q, pend_q, err_q;
  logic [15:0] cnt_q;

  logic wr_in_range, rd_in_range, wr_ok;
  assign wr_in_range = (wr_addr < DEPTH_A);
  assign rd_in_range = (rd_addr < DEPTH_A);
  assign wr_ok       = wr_en & ready_q & wr_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      front_q <= 1'b0;
      ready_q <= 1'b1;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_en && !(ready_q && wr_in_range)) err_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (wr_frame_done) begin
            if (rd_frame_end) begin
              front_q <= ~front_q;
              cnt_q   <= cnt_q + 16'd1;
            end else begin
              state_q <= ST_PENDING;
              ready_q <= 1'b0;
              pend_q  <= 1'b1;
            end
          end
        end
        ST_PENDING: begin
          if (wr_frame_done) err_q <= 1'b1;
          if (rd_frame_end) begin
            front_q <= ~front_q;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            pend_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign front_bank   = front_q;
  assign wr_ready     = ready_q;
  assign swap_pending = pend_q;
  assign swap_count   = cnt_q;
  assign wr_err       = err_q;

  logic [DATA_W-1:0] q0, q1;

  bram_sdp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok & front_q),
    .waddr (wr_addr[MEM_AW-1:0]),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr[MEM_AW-1:0]),
    .rdata (q0)
  );

  bram_sdp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank1 (
    .clk   (clk),
    .we    (wr_ok & ~front_q),
    .waddr (wr_addr[MEM_AW-1:0]),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr[MEM_AW-1:0]),
    .rdata (q1)
  );

  // Bank and range flags only move on a read so the muxed data holds between reads;
  // the zero flag also masks the unreset RAM output after reset.
  logic              rd_v1_q, rd_zero1_q;
  bank_t             rd_bank1_q;
  logic [DATA_W-1:0] rd_data1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v1_q    <= 1'b0;
      rd_bank1_q <= 1'b0;
      rd_zero1_q <= 1'b1;
    end else begin
      rd_v1_q <= rd_en;
      if (rd_en) begin
        rd_bank1_q <= front_q;
        rd_zero1_q <= ~rd_in_range;
      end
    end
  end

  assign rd_data1 = rd_zero1_q ? '0 : (rd_bank1_q ? q1 : q0);

  // Any RD_LAT other than 2 behaves as latency 1.
  if (RD_LAT == 2) begin : g_lat2
    logic              rd_v2_q;
    logic [DATA_W-1:0] rd_data2_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_v2_q    <= 1'b0;
        rd_data2_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) rd_data2_q <= rd_data1;
      end
    end
    assign rd_valid = rd_v2_q;
    assign rd_data  = rd_data2_q;
  end else begin : g_lat1
    assign rd_valid = rd_v1_q;
    assign rd_data  = rd_data1;
  end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Scoreboard bench: one stimulus stream drives a latency-1 and a latency-2 instance.
module tb_frame_buffer_pingpong;
  import frame_buffer_pkg::*;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int          NPIX   = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = addr_w(IMG_W * IMG_H);

  logic              clk = 1'b0;
  logic              rst_n, wr_en, wr_frame_done, rd_en, rd_frame_end;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;

  logic [1:0]             ready_v, valid_v, front_v, pend_v, err_v;
  logic [1:0][DATA_W-1:0] data_v;
  logic [1:0][15:0]       cnt_v;

  always #5 clk = ~clk;

  frame_buffer_pingpong #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_ready(ready_v[0]), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(data_v[0]), .rd_valid(valid_v[0]), .rd_frame_end(rd_frame_end),
    .front_bank(front_v[0]), .swap_pending(pend_v[0]), .swap_count(cnt_v[0]), .wr_err(err_v[0])
  );

  frame_buffer_pingpong #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_ready(ready_v[1]), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(data_v[1]), .rd_valid(valid_v[1]), .rd_frame_end(rd_frame_end),
    .front_bank(front_v[1]), .swap_pending(pend_v[1]), .swap_count(cnt_v[1]), .wr_err(err_v[1])
  );

  // Reference model: two pixel arrays plus the swap rules.
  logic [DATA_W-1:0] m_mem [2][NPIX];
  bit                m_front, m_pend, m_err;
  logic [15:0]       m_cnt;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                iss;
  } exp_t;
  exp_t              q[$];
  int                idx[2];
  logic [DATA_W-1:0] last[2];
  int                edges = 0;
  int                tests = 0;
  int                fails = 0;
  bit                mon_on = 0;

  task automatic chk(input string name, input int k, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (lat%0d): got %0h, expected %0h", name, k + 1, act, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (!rst_n) begin
      m_front = 0; m_pend = 0; m_err = 0; m_cnt = '0;
      q.delete(); idx[0] = 0; idx[1] = 0; last[0] = '0; last[1] = '0;
    end else begin
      if (wr_en) begin
        if (!m_pend && int'(wr_addr) < NPIX) m_mem[!m_front][int'(wr_addr)] = wr_data;
        else m_err = 1;
      end
      if (rd_en) begin
        e.d   = (int'(rd_addr) < NPIX) ? m_mem[m_front][int'(rd_addr)] : '0;
        e.iss = edges;
        q.push_back(e);
      end
      if (m_pend && wr_frame_done) m_err = 1;
      if (rd_frame_end && (m_pend || wr_frame_done)) begin
        m_front = !m_front;
        m_cnt   = m_cnt + 16'd1;
        m_pend  = 0;
      end else if (wr_frame_done) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic check_status();
    for (int k = 0; k < 2; k++) begin
      chk("front_bank", k, 16'(front_v[k]), 16'(m_front));
      chk("swap_pending", k, 16'(pend_v[k]), 16'(m_pend));
      chk("wr_ready", k, 16'(ready_v[k]), 16'(!m_pend));
      chk("swap_count", k, cnt_v[k], m_cnt);
      chk("wr_err", k, 16'(err_v[k]), 16'(m_err));
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_status();
  endtask

  task automatic clr();
    wr_en = 0; rd_en = 0; wr_frame_done = 0; rd_frame_end = 0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) tick();
  endtask

  task automatic pulse(input bit wfd, input bit rfe);
    clr();
    wr_frame_done = wfd; rd_frame_end = rfe;
    tick();
    clr();
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    clr();
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    clr();
  endtask

  task automatic rd(input int a);
    clr();
    rd_en = 1; rd_addr = ADDR_W'(a);
    tick();
    clr();
  endtask

  // mode 0: data = address, 1: constant val, 2: random
  task automatic fill(input int mode, input logic [DATA_W-1:0] val);
    for (int i = 0; i < NPIX; i++)
      wr(i, (mode == 0) ? DATA_W'(i) : (mode == 1) ? val : DATA_W'($urandom));
  endtask

  task automatic read_all();
    for (int i = 0; i < NPIX; i++) rd(i);
    idle(3);
  endtask

  // Monitor: pops expected reads per instance and checks latency, data and hold.
  initial forever begin
    int   due;
    bit   has;
    @(posedge clk);
    #1;
    edges++;
    if (mon_on) begin
      for (int k = 0; k < 2; k++) begin
        has = idx[k] < q.size();
        due = has ? q[idx[k]].iss + k + 1 : -1;
        if (valid_v[k]) begin
          tests++;
          if (!has || due != edges) begin
            fails++;
            $display("FAIL rd_valid_unexpected (lat%0d): edge %0d, next due %0d", k + 1,
                     edges, due);
          end else begin
            if (data_v[k] !== q[idx[k]].d) begin
              fails++;
              $display("FAIL rd_data (lat%0d): got %0h, expected %0h", k + 1, data_v[k],
                       q[idx[k]].d);
            end
            idx[k]++;
          end
          last[k] = data_v[k];
        end else begin
          if (has && due <= edges) begin
            tests++; fails++;
            $display("FAIL rd_valid_missing (lat%0d): got 0, expected 1 at edge %0d", k + 1,
                     due);
            idx[k]++;
          end
          tests++;
          if (data_v[k] !== last[k]) begin
            fails++;
            $display("FAIL rd_data_hold (lat%0d): got %0h, expected %0h", k + 1, data_v[k],
                     last[k]);
          end
        end
      end
      while (q.size() > 0 && idx[0] > 0 && idx[1] > 0) begin
        void'(q.pop_front());
        idx[0]--; idx[1]--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    clr();
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    rst_n = 0;
    tick(); tick();
    mon_on = 1;
    rst_n = 1;
    idle(2);

    // Fill and swap
    fill(0, '0);
    pulse(1, 0);
    pulse(0, 1);
    chk("fill_swap_front", 0, 16'(front_v[0]), 16'd1);
    chk("fill_swap_count", 0, cnt_v[0], 16'd1);
    read_all();

    // Simultaneous pulses, then bank 1 front holding 0xAA
    fill(1, 8'hAA);
    pulse(1, 1);
    chk("simul_front", 0, 16'(front_v[0]), 16'd0);
    chk("simul_count", 0, cnt_v[0], 16'd2);
    fill(1, 8'hAA);
    pulse(1, 0);
    pulse(0, 1);

    // No tearing
    fill(1, 8'h55);
    pulse(1, 0);
    for (int i = 0; i < 10; i++) rd($urandom_range(0, NPIX - 1));
    chk("no_tear_pending", 1, 16'(pend_v[1]), 16'd1);
    chk("no_tear_ready", 1, 16'(ready_v[1]), 16'd0);
    pulse(0, 1);
    read_all();

    // Errors
    wr(32, 8'h77);
    chk("err_oob_write", 0, 16'(err_v[0]), 16'd1);
    pulse(1, 0);
    wr(3, 8'hEE);
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 1);
    rd(0); rd(3); rd(40);
    idle(3);
    chk("err_sticky", 0, 16'(err_v[0]), 16'd1);

    // Continuous reads across a swap
    fill(2, '0);
    pulse(1, 0);
    clr();
    for (int i = 0; i < 20; i++) begin
      rd_en = 1; rd_addr = ADDR_W'($urandom_range(0, NPIX - 1));
      rd_frame_end = (i == 8);
      tick();
    end
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom); wr_addr = ADDR_W'($urandom_range(0, 40));
      wr_data = DATA_W'($urandom);
      rd_en = 1'($urandom); rd_addr = ADDR_W'($urandom_range(0, 40));
      wr_frame_done = ($urandom % 16 == 0);
      rd_frame_end  = ($urandom % 12 == 0);
      tick();
    end
    idle(4);

    // Reset mid-PENDING
    if (!m_pend) pulse(1, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_front", 0, 16'(front_v[0]), 16'd0);
    chk("rst_pending", 0, 16'(pend_v[0]), 16'd0);
    chk("rst_count", 1, cnt_v[1], 16'd0);
    pulse(0, 1);
    chk("rst_no_swap", 0, 16'(front_v[0]), 16'd0);
    for (int i = 0; i < 8; i++) rd($urandom_range(0, NPIX - 1));
    idle(5);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
